// File: rtl/pair_loader_pkg.sv
// Shared definitions for the pair loader block.
//   - state_t : FSM encoding (S_A collects the first byte, S_B the second,
//               S_OUT presents the assembled pair downstream).
//   - DEF_DATA_W / DEF_PAD_VAL : default byte width and odd-stream pad value.
package pair_pkg;

    localparam int         DEF_DATA_W  = 8;
    localparam logic [7:0] DEF_PAD_VAL = 8'h00;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OUT = 2'd2
    } state_t;

endpackage

// File: rtl/pair_loader_if.sv
// Handshake bundle between the byte source, the pair loader and the swap stage.
//   Byte side : in_data, in_valid, in_last (to loader), in_ready (from loader)
//   Pair side : out_a, out_b, out_valid, out_last, out_padded, out_swapped,
//               pair_count (from loader), out_ready (to loader)
//   modport slave  : the pair loader's view
//   modport master : the environment's view (byte source + pair sink)
interface pair_loader_if #(
    parameter int DATA_W = pair_pkg::DEF_DATA_W,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic              out_valid;
    logic              out_last;
    logic              out_padded;
    logic              out_swapped;
    logic              out_ready;
    logic [CNT_W-1:0]  pair_count;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_a, out_b, out_valid, out_last, out_padded,
               out_swapped, pair_count
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_a, out_b, out_valid, out_last, out_padded,
               out_swapped, pair_count
    );

endinterface

// File: rtl/pair_loader_order_cmp.sv
// pair_order_cmp: combinational unsigned compare-and-order of two values.
//   x, y    : inputs, x is the first byte of the pair
//   lo, hi  : min(x, y) and max(x, y); ties keep the original order
//   swapped : 1 when x > y, i.e. the outputs are exchanged
module pair_order_cmp #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi,
    output logic              swapped
);

    assign swapped = (x > y);
    assign lo      = swapped ? y : x;
    assign hi      = swapped ? x : y;

endmodule

// File: rtl/pair_loader.sv
// pair_loader: assembles a valid/ready byte stream into (A, B) pairs for the
// byte-pair swap stage. Each pair is held on registered outputs until the
// downstream accepts it; an odd-length stream is closed with B = PAD_VAL.
// A running count of delivered pairs wraps silently at 2^CNT_W.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (discards any partial/pending pair)
//   bus  : pair_loader_if.slave (byte input handshake, pair output handshake,
//          pair_count)
//
// Build option: define PAIR_ORDER_EN to order each pair so out_a <= out_b
// (unsigned) and flag reordered pairs on out_swapped. Without it no
// comparator is built and out_swapped is always 0.
module pair_loader
    import pair_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter int                CNT_W   = 16,
    parameter logic [DATA_W-1:0] PAD_VAL = DATA_W'(DEF_PAD_VAL)
) (
    input  logic          clk,
    input  logic          rst,
    pair_loader_if.slave  bus
);

    state_t            state_q,   state_d;
    logic [DATA_W-1:0] a_q,       a_d;
    logic [DATA_W-1:0] b_q,       b_d;
    logic              last_q,    last_d;
    logic              padded_q,  padded_d;
    logic              swapped_q, swapped_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic              accept;
    logic              deliver;
    logic              capture;
    logic [DATA_W-1:0] cap_first;
    logic [DATA_W-1:0] cap_second;
    logic [DATA_W-1:0] ord_a;
    logic [DATA_W-1:0] ord_b;
    logic              ord_sw;

    assign bus.in_ready = (state_q != S_OUT);
    assign accept       = bus.in_valid && bus.in_ready;
    assign deliver      = (state_q == S_OUT) && bus.out_ready;

    // A pair is complete either on the second byte, or on a last byte that
    // arrives as the first of a pair (padded path).
    assign capture = accept && ((state_q == S_B) || bus.in_last);

    // Candidate pair as it would be stored on capture. in_data only reaches
    // the registers when it is actually accepted.
    assign cap_first  = (state_q == S_A) ? bus.in_data : a_q;
    assign cap_second = (state_q == S_A) ? PAD_VAL     : bus.in_data;

`ifdef PAIR_ORDER_EN
    pair_order_cmp #(
        .DATA_W (DATA_W)
    ) u_order_cmp (
        .x       (cap_first),
        .y       (cap_second),
        .lo      (ord_a),
        .hi      (ord_b),
        .swapped (ord_sw)
    );
`else
    assign ord_a  = cap_first;
    assign ord_b  = cap_second;
    assign ord_sw = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        last_d    = last_q;
        padded_d  = padded_q;
        swapped_d = swapped_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_A: begin
                if (accept) begin
                    if (bus.in_last) begin
                        state_d = S_OUT;
                    end else begin
                        a_d     = bus.in_data;
                        state_d = S_B;
                    end
                end
            end
            S_B: begin
                if (accept) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (deliver) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_A;
                end
            end
            default: state_d = S_A;
        endcase

        if (capture) begin
            a_d       = ord_a;
            b_d       = ord_b;
            last_d    = bus.in_last;
            padded_d  = (state_q == S_A);
            swapped_d = ord_sw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_A;
            a_q       <= '0;
            b_q       <= '0;
            last_q    <= 1'b0;
            padded_q  <= 1'b0;
            swapped_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            last_q    <= last_d;
            padded_q  <= padded_d;
            swapped_q <= swapped_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.out_a       = a_q;
    assign bus.out_b       = b_q;
    assign bus.out_valid   = (state_q == S_OUT);
    assign bus.out_last    = last_q;
    assign bus.out_padded  = padded_q;
    assign bus.out_swapped = swapped_q;
    assign bus.pair_count  = cnt_q;

endmodule

// File: tb/tb_pair_loader.sv
// Scoreboard bench for pair_loader: stimulus pushes the expected pair when it
// sends bytes; a negedge monitor pops and compares on every delivery, and also
// watches hold-stability during back-pressure. A second instance with CNT_W=4
// exercises counter wrap.
module tb_pair_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pair_loader_if #(.DATA_W(8), .CNT_W(16)) bus ();
    pair_loader_if #(.DATA_W(8), .CNT_W(4))  bus4 ();

    pair_loader #(.DATA_W(8), .CNT_W(16), .PAD_VAL(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pair_loader #(.DATA_W(8), .CNT_W(4), .PAD_VAL(8'h00)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        last;
        logic        pad;
        logic        sw;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    logic [15:0] exp_cnt  = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b,
                            input logic last, input logic pad, input logic sw);
        exp_t e;
        e.a = a; e.b = b; e.last = last; e.pad = pad; e.sw = sw; e.cnt = exp_cnt;
        sb_q.push_back(e);
        exp_cnt = exp_cnt + 16'd1;
    endtask

    // Offer one byte and return just after the edge that accepted it.
    task automatic send_byte(input logic [7:0] d, input logic last);
        logic acc;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_checks++;
            n_err++;
            $display("FAIL send_byte_timeout: byte %0h never accepted", d);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'hxx;
    endtask

    task automatic send4(input logic [7:0] d, input logic last);
        logic acc;
        bus4.in_data  = d;
        bus4.in_last  = last;
        bus4.in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bus4.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_checks++;
            n_err++;
            $display("FAIL send4_timeout: byte %0h never accepted", d);
        end
        bus4.in_valid = 1'b0;
        bus4.in_last  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_timeout: %0d pairs pending, required 0", sb_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor
    logic        prev_valid = 1'b0;
    logic        prev_deliv = 1'b0;
    logic [15:0] cnt_after  = 16'd0;
    logic [7:0]  h_a, h_b;
    logic        h_last, h_pad, h_sw;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_deliv = 1'b0;
        end else begin
            if (prev_deliv) begin
                chk("valid_drop_after_deliver", {31'd0, bus.out_valid}, 32'd0);
                chk("count_after_deliver", {16'd0, bus.pair_count}, {16'd0, cnt_after});
            end
            prev_deliv = 1'b0;
            if (bus.out_valid) begin
                chk("in_ready_low_while_valid", {31'd0, bus.in_ready}, 32'd0);
                if (prev_valid) begin
                    chk("hold_stable", {bus.out_a, bus.out_b, 5'd0, bus.out_last, bus.out_padded, bus.out_swapped},
                        {h_a, h_b, 5'd0, h_last, h_pad, h_sw});
                end
                h_a = bus.out_a; h_b = bus.out_b; h_last = bus.out_last;
                h_pad = bus.out_padded; h_sw = bus.out_swapped;
                if (bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_pair: got %0h/%0h, required none", bus.out_a, bus.out_b);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("out_a", {24'd0, bus.out_a}, {24'd0, e.a});
                        chk("out_b", {24'd0, bus.out_b}, {24'd0, e.b});
                        chk("out_last", {31'd0, bus.out_last}, {31'd0, e.last});
                        chk("out_padded", {31'd0, bus.out_padded}, {31'd0, e.pad});
                        chk("out_swapped", {31'd0, bus.out_swapped}, {31'd0, e.sw});
                        chk("pair_count_at_deliver", {16'd0, bus.pair_count}, {16'd0, e.cnt});
                        cnt_after  = e.cnt + 16'd1;
                        prev_deliv = 1'b1;
                    end
                end
            end
            prev_valid = bus.out_valid && !bus.out_ready;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_data    = 8'h00;
        bus.in_valid   = 1'b0;
        bus.in_last    = 1'b0;
        bus.out_ready  = 1'b1;
        bus4.in_data   = 8'h00;
        bus4.in_valid  = 1'b0;
        bus4.in_last   = 1'b0;
        bus4.out_ready = 1'b1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_out_valid",   {31'd0, bus.out_valid},   32'd0);
        chk("rst_in_ready",    {31'd0, bus.in_ready},    32'd1);
        chk("rst_out_a",       {24'd0, bus.out_a},       32'd0);
        chk("rst_out_b",       {24'd0, bus.out_b},       32'd0);
        chk("rst_out_last",    {31'd0, bus.out_last},    32'd0);
        chk("rst_out_padded",  {31'd0, bus.out_padded},  32'd0);
        chk("rst_out_swapped", {31'd0, bus.out_swapped}, 32'd0);
        chk("rst_pair_count",  {16'd0, bus.pair_count},  32'd0);

        // Plain pair, already in order
        push_exp(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        chk("latency_valid_after_second", {31'd0, bus.out_valid}, 32'd1);
        drain();
        chk("count_after_first_pair", {16'd0, bus.pair_count}, 32'd1);

        // Odd stream: padded last byte
`ifdef PAIR_ORDER_EN
        push_exp(8'h00, 8'h05, 1'b1, 1'b1, 1'b1);
`else
        push_exp(8'h05, 8'h00, 1'b1, 1'b1, 1'b0);
`endif
        send_byte(8'h05, 1'b1);
        chk("latency_valid_after_pad", {31'd0, bus.out_valid}, 32'd1);
        drain();

        // Back-pressure for 5 cycles, with an ignored byte offered meanwhile
        bus.out_ready = 1'b0;
`ifdef PAIR_ORDER_EN
        push_exp(8'h55, 8'hAA, 1'b1, 1'b0, 1'b1);
`else
        push_exp(8'hAA, 8'h55, 1'b1, 1'b0, 1'b0);
`endif
        send_byte(8'hAA, 1'b0);
        send_byte(8'h55, 1'b1);
        bus.in_data  = 8'hEE;
        bus.in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("stall_still_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        chk("stall_no_extra_accept", {31'd0, bus.in_ready}, 32'd1);

        // Descending pair
`ifdef PAIR_ORDER_EN
        push_exp(8'h10, 8'h90, 1'b0, 1'b0, 1'b1);
`else
        push_exp(8'h90, 8'h10, 1'b0, 1'b0, 1'b0);
`endif
        send_byte(8'h90, 1'b0);
        send_byte(8'h10, 1'b0);
        drain();
        chk("count_before_reset", {16'd0, bus.pair_count}, 32'd4);

        // Reset with a half-built pair
        send_byte(8'h77, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_cnt = 16'd0;
        chk("midrst_out_valid",  {31'd0, bus.out_valid},  32'd0);
        chk("midrst_in_ready",   {31'd0, bus.in_ready},   32'd1);
        chk("midrst_pair_count", {16'd0, bus.pair_count}, 32'd0);
        push_exp(8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        drain();

        // Counter wrap on the CNT_W=4 instance
        for (int p = 0; p < 17; p++) begin
            send4(8'(2 * p), 1'b0);
            send4(8'(2 * p + 1), 1'b0);
            @(posedge clk);
            #1;
            if (p == 15) chk("cnt4_wrap_to_0", {28'd0, bus4.pair_count}, 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("cnt4_after_17", {28'd0, bus4.pair_count}, 32'd1);

        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
